// File: rtl/cmd_decoder_q.sv
// SPI command decoder with a frame queue.
// Incoming frames {CMD, ADDR, VAL} are buffered in a small FIFO and executed
// strictly in arrival order against a register bank or the memory controller.
// Responses leave through the TX trigger/busy handshake. Every handshake wait
// is guarded by a timeout. Frame drops and timeouts raise sticky error flags.
module cmd_decoder_q #(
    parameter int          DATA_W     = 8,
    parameter int          NUM_REGS   = 4,
    parameter int          FIFO_DEPTH = 4,
    parameter int          TIMEOUT    = 1024,
    parameter logic [15:0] ID_WORD    = 16'h7975
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                RX_VALID,
    input  logic [8+DATA_W-1:0] RX_DATA,
    output logic                TX_TRIG,
    input  logic                TX_BUSY,
    output logic [47:0]         TX_DATA,
    output logic [2:0]          TX_TYPE,
    output logic                MEM_TRIG,
    output logic [7:0]          MEM_CMD,
    input  logic                MEM_BUSY,
    input  logic [47:0]         MEM_DATA,
    output logic [2:0]          MEM_TYPE_OUT,
    output logic                OVERFLOW,
    output logic                TMO_ERR,
    input  logic                ERR_CLR
);

    localparam int FRAME_W = 8 + DATA_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int TMO_W   = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_MEM_REQ, S_MEM_WAIT, S_TX_PEND, S_TX_REQ, S_TX_WAIT
    } state_t;

    state_t state_q, state_d;

    // ---------------- command FIFO ----------------
    logic [FRAME_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr, rd_ptr;
    logic               fifo_empty, fifo_full, pop, push, drop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop  = (state_q == S_IDLE) && !fifo_empty;
    // A pop in the same cycle frees a slot, so a write on a full FIFO is still accepted.
    assign push = RX_VALID && (!fifo_full || pop);
    assign drop = RX_VALID && fifo_full && !pop;

    // Frame storage.
    // NOTE: storage has no reset; the pointers alone define what is valid, so stale data is never read.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= RX_DATA;
    end

    // FIFO pointers; the extra MSB distinguishes full from empty.
    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- current command ----------------
    logic [3:0]        cmd_q, addr_q;
    logic [DATA_W-1:0] val_q;

    // Latch the frame popped from the FIFO for decoding.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cmd_q  <= '0;
            addr_q <= '0;
            val_q  <= '0;
        end else if (pop) begin
            cmd_q  <= fifo_mem[rd_ptr[PTR_W-1:0]][FRAME_W-1 -: 4];
            addr_q <= fifo_mem[rd_ptr[PTR_W-1:0]][FRAME_W-5 -: 4];
            val_q  <= fifo_mem[rd_ptr[PTR_W-1:0]][DATA_W-1:0];
        end
    end

    // ---------------- register bank ----------------
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] reg_rd;
    logic              reg_hit;

    // Register read mux; ADDR beyond the bank leaves reg_hit low.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        reg_hit = 1'b0;
        reg_rd  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == 4'(i)) begin
                reg_hit = 1'b1;
                reg_rd  = regs[i];
            end
        end
    end

    // Register bank: defaults are i*0x11, SET writes one entry, RESET_REGS restores all.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= DATA_W'(i * 32'h11);
        end else if (state_q == S_DECODE) begin
            if (cmd_q == 4'd4) begin
                for (int i = 0; i < NUM_REGS; i++) regs[i] <= DATA_W'(i * 32'h11);
            end else if (cmd_q == 4'd2) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (addr_q == 4'(i)) regs[i] <= val_q;
                end
            end
        end
    end

    // ---------------- memory opcode table ----------------
    logic       op_valid;
    logic [7:0] op_code;
    logic [2:0] op_len;

    // Map MEM_ID / MEM_OP frames to a memory opcode and response length.
    always_comb begin
        op_valid = 1'b0;
        op_code  = 8'h00;
        op_len   = 3'b000;
        if (cmd_q == 4'd7) begin
            op_valid = 1'b1; op_code = 8'h9F; op_len = 3'b110;
        end else if (cmd_q == 4'd8) begin
            case (addr_q)
                4'd0:    begin op_valid = 1'b1; op_code = 8'h05; op_len = 3'b001; end
                4'd1:    begin op_valid = 1'b1; op_code = 8'h07; op_len = 3'b001; end
                4'd2:    begin op_valid = 1'b1; op_code = 8'hAB; op_len = 3'b001; end
                4'd3:    begin op_valid = 1'b1; op_code = 8'h06; op_len = 3'b000; end
                4'd4:    begin op_valid = 1'b1; op_code = 8'hC7; op_len = 3'b000; end
                default: ;
            endcase
        end
    end

    // ---------------- handshake timeout ----------------
    logic [TMO_W-1:0] tmo_cnt;
    logic             waiting, tmo_hit;

    assign waiting = (state_q == S_MEM_REQ) || (state_q == S_MEM_WAIT) ||
                     (state_q == S_TX_PEND) || (state_q == S_TX_REQ)   ||
                     (state_q == S_TX_WAIT);
    assign tmo_hit = waiting && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    // Cycles spent in the current state; restarts on every state change.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                 tmo_cnt <= '0;
        else if (state_d != state_q) tmo_cnt <= '0;
        else if (waiting)           tmo_cnt <= tmo_cnt + 1'b1;
    end

    // ---------------- FSM ----------------
    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a timeout aborts any handshake wait back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!fifo_empty) state_d = S_DECODE;
            S_DECODE: begin
                case (cmd_q)
                    4'd3, 4'd6: state_d = S_TX_REQ;
                    4'd7, 4'd8: state_d = op_valid ? S_MEM_REQ : S_IDLE;
                    default:    state_d = S_IDLE;
                endcase
            end
            S_MEM_REQ:  if (tmo_hit) state_d = S_IDLE;
                        else if (MEM_BUSY) state_d = S_MEM_WAIT;
            S_MEM_WAIT: begin
                if (tmo_hit)                    state_d = S_IDLE;
                else if (!MEM_BUSY) begin
                    if (MEM_TYPE_OUT == 3'b000) state_d = S_IDLE;
                    else if (TX_BUSY)           state_d = S_TX_PEND;
                    else                        state_d = S_TX_REQ;
                end
            end
            S_TX_PEND:  if (tmo_hit) state_d = S_IDLE;
                        else if (!TX_BUSY) state_d = S_TX_REQ;
            S_TX_REQ:   if (tmo_hit) state_d = S_IDLE;
                        else if (TX_BUSY) state_d = S_TX_WAIT;
            S_TX_WAIT:  if (tmo_hit || !TX_BUSY) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Trigger outputs decoded from state, so reset drops them immediately.
    always_comb begin
        TX_TRIG  = (state_q == S_TX_REQ);
        MEM_TRIG = (state_q == S_MEM_REQ);
    end

    // Response / memory-request datapath; everything clears while idle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            TX_DATA      <= '0;
            TX_TYPE      <= '0;
            MEM_CMD      <= '0;
            MEM_TYPE_OUT <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    TX_DATA      <= '0;
                    TX_TYPE      <= '0;
                    MEM_CMD      <= '0;
                    MEM_TYPE_OUT <= '0;
                end
                S_DECODE: begin
                    if (cmd_q == 4'd3) begin
                        TX_DATA <= reg_hit ? 48'({cmd_q, addr_q, reg_rd}) : 48'({cmd_q, 12'h123});
                        TX_TYPE <= 3'b010;
                    end else if (cmd_q == 4'd6) begin
                        TX_DATA <= 48'(ID_WORD);
                        TX_TYPE <= 3'b010;
                    end else if (op_valid) begin
                        MEM_CMD      <= op_code;
                        MEM_TYPE_OUT <= op_len;
                    end
                end
                S_MEM_WAIT: begin
                    if (!tmo_hit && !MEM_BUSY && MEM_TYPE_OUT != 3'b000) begin
                        TX_DATA <= MEM_DATA;
                        TX_TYPE <= MEM_TYPE_OUT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle overrides ERR_CLR.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OVERFLOW <= 1'b0;
            TMO_ERR  <= 1'b0;
        end else begin
            OVERFLOW <= drop    | (OVERFLOW & ~ERR_CLR);
            TMO_ERR  <= tmo_hit | (TMO_ERR  & ~ERR_CLR);
        end
    end

endmodule

// File: tb/tb_cmd_decoder_q.sv
// Scoreboard testbench for cmd_decoder_q.
// Stimulus pushes expected TX responses and memory requests into queues.
// A monitor pops and compares them whenever a trigger rises.
// Background responders model the SPI transmitter and the memory controller.
module tb_cmd_decoder_q;

    localparam int DATA_W     = 8;
    localparam int NUM_REGS   = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 32;

    localparam int TX_AUTO = 0;
    localparam int TX_HIGH = 1;
    localparam int TX_LOW  = 2;

    logic        CLK, RST_N, RX_VALID, TX_TRIG, TX_BUSY, MEM_TRIG, MEM_BUSY;
    logic        OVERFLOW, TMO_ERR, ERR_CLR;
    logic [15:0] RX_DATA;
    logic [47:0] TX_DATA, MEM_DATA;
    logic [2:0]  TX_TYPE, MEM_TYPE_OUT;
    logic [7:0]  MEM_CMD;

    typedef struct packed { logic [47:0] data; logic [2:0] typ; } tx_exp_t;
    typedef struct packed { logic [7:0]  cmd;  logic [2:0] len; } mem_exp_t;

    tx_exp_t  tx_q[$];
    mem_exp_t mem_q[$];
    int       n_tests = 0;
    int       n_fail  = 0;

    int          tx_mode;
    int          tx_cnt, mem_cnt;
    logic        mem_hold;
    logic [47:0] mem_rdata;

    cmd_decoder_q #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .FIFO_DEPTH(FIFO_DEPTH),
        .TIMEOUT(TIMEOUT), .ID_WORD(16'h7975)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
        .TX_TRIG(TX_TRIG), .TX_BUSY(TX_BUSY), .TX_DATA(TX_DATA), .TX_TYPE(TX_TYPE),
        .MEM_TRIG(MEM_TRIG), .MEM_CMD(MEM_CMD), .MEM_BUSY(MEM_BUSY), .MEM_DATA(MEM_DATA),
        .MEM_TYPE_OUT(MEM_TYPE_OUT), .OVERFLOW(OVERFLOW), .TMO_ERR(TMO_ERR), .ERR_CLR(ERR_CLR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_tx(input logic [47:0] d, input logic [2:0] t);
        tx_q.push_back('{data: d, typ: t});
    endtask

    task automatic exp_mem(input logic [7:0] c, input logic [2:0] l);
        mem_q.push_back('{cmd: c, len: l});
    endtask

    task automatic send(input logic [15:0] f);
        @(negedge CLK);
        RX_VALID = 1'b1;
        RX_DATA  = f;
        @(negedge CLK);
        RX_VALID = 1'b0;
    endtask

    // Wait until all expectations are consumed and both handshakes are quiet.
    task automatic drain(input string name);
        int k;
        k = 0;
        while (k < 300 && !(tx_q.size() == 0 && mem_q.size() == 0 && !TX_TRIG &&
                            !MEM_TRIG && !TX_BUSY && !MEM_BUSY)) begin
            @(negedge CLK);
            k++;
        end
        check({name, "_completed"}, 64'(k < 300), 1);
        repeat (4) @(negedge CLK);
    endtask

    // Monitor: compare on every rising trigger.
    initial begin
        logic     tx_d, mem_d;
        tx_exp_t  te;
        mem_exp_t me;
        tx_d  = 1'b0;
        mem_d = 1'b0;
        forever begin
            @(negedge CLK);
            if (TX_TRIG && !tx_d) begin
                check("tx_expected", 64'(tx_q.size() > 0), 1);
                if (tx_q.size() > 0) begin
                    te = tx_q.pop_front();
                    check("tx_data", TX_DATA, te.data);
                    check("tx_type", TX_TYPE, te.typ);
                end
            end
            if (MEM_TRIG && !mem_d) begin
                check("mem_expected", 64'(mem_q.size() > 0), 1);
                if (mem_q.size() > 0) begin
                    me = mem_q.pop_front();
                    check("mem_cmd", MEM_CMD, me.cmd);
                    check("mem_type", MEM_TYPE_OUT, me.len);
                end
            end
            tx_d  = TX_TRIG;
            mem_d = MEM_TRIG;
        end
    end

    // SPI transmitter model: busy for 3 cycles per trigger, or forced high/low.
    initial begin
        TX_BUSY = 1'b0;
        tx_cnt  = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (!RST_N) begin
                TX_BUSY = 1'b0;
                tx_cnt  = 0;
            end else if (tx_mode == TX_HIGH) begin
                TX_BUSY = 1'b1;
                tx_cnt  = 0;
            end else if (tx_mode == TX_LOW) begin
                TX_BUSY = 1'b0;
                tx_cnt  = 0;
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) TX_BUSY = 1'b0;
            end else if (TX_BUSY) begin
                TX_BUSY = 1'b0;
            end else if (TX_TRIG) begin
                TX_BUSY = 1'b1;
                tx_cnt  = 3;
            end
        end
    end

    // Memory controller model: busy for 5 cycles per trigger (frozen while mem_hold).
    initial begin
        MEM_BUSY = 1'b0;
        MEM_DATA = '0;
        mem_cnt  = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (!RST_N) begin
                MEM_BUSY = 1'b0;
                mem_cnt  = 0;
            end else if (mem_cnt > 0) begin
                if (!mem_hold) begin
                    mem_cnt--;
                    if (mem_cnt == 0) MEM_BUSY = 1'b0;
                end
            end else if (MEM_TRIG && !MEM_BUSY) begin
                MEM_BUSY = 1'b1;
                MEM_DATA = mem_rdata;
                mem_cnt  = 5;
            end
        end
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // Directed stimulus.
    initial begin
        logic [15:0] burst [6];
        int          k;
        burst[0] = 16'h3100; burst[1] = 16'h3200; burst[2] = 16'h6000;
        burst[3] = 16'h3300; burst[4] = 16'h20AA; burst[5] = 16'h3F00;

        RST_N = 1'b1; RX_VALID = 1'b0; RX_DATA = '0; ERR_CLR = 1'b0;
        tx_mode = TX_AUTO; mem_hold = 1'b0; mem_rdata = '0;
        #1 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_tx_trig",  TX_TRIG, 0);
        check("rst_mem_trig", MEM_TRIG, 0);
        check("rst_tx_data",  TX_DATA, 0);
        check("rst_types",    {TX_TYPE, MEM_TYPE_OUT, MEM_CMD}, 0);
        check("rst_flags",    {OVERFLOW, TMO_ERR}, 0);
        RST_N = 1'b1;
        @(negedge CLK);

        // SET reg1 then GET reg1.
        send(16'h2155);
        exp_tx(48'h3155, 3'b010);
        send(16'h3100);
        drain("set_get");
        check("idle_tx_data_cleared", TX_DATA, 0);
        check("idle_tx_type_cleared", TX_TYPE, 0);

        // Out-of-range GET/SET, invalid MEM_OP address, unknown command.
        exp_tx(48'h3123, 3'b010);
        send(16'h3500);
        send(16'h25AA);
        send(16'h8700);
        send(16'hF000);
        exp_tx(48'h3155, 3'b010);
        send(16'h3100);
        drain("boundary");

        // Burst of 6 frames while the transmitter is stuck busy.
        tx_mode = TX_HIGH;
        repeat (2) @(negedge CLK);
        exp_tx(48'h3000, 3'b010);
        send(16'h3000);
        repeat (5) @(negedge CLK);
        exp_tx(48'h3155, 3'b010);
        exp_tx(48'h3222, 3'b010);
        exp_tx(48'h7975, 3'b010);
        exp_tx(48'h3333, 3'b010);
        for (int i = 0; i < 6; i++) begin
            RX_VALID = 1'b1;
            RX_DATA  = burst[i];
            @(negedge CLK);
        end
        RX_VALID = 1'b0;
        check("burst_overflow", OVERFLOW, 1);
        tx_mode = TX_AUTO;
        drain("burst");
        exp_tx(48'h3000, 3'b010);
        send(16'h3000);
        drain("dropped_set");
        check("overflow_sticky", OVERFLOW, 1);

        // MEM_ID with 6-byte response.
        mem_rdata = 48'h0120184D0180;
        exp_mem(8'h9F, 3'b110);
        exp_tx(48'h0120184D0180, 3'b110);
        send(16'h7000);
        drain("mem_id");

        // MEM_OP read status, 1-byte response.
        mem_rdata = 48'h0000000000A5;
        exp_mem(8'h05, 3'b001);
        exp_tx(48'h0000000000A5, 3'b001);
        send(16'h8000);
        drain("mem_rdsr");

        // MEM_OP without a response: WREN and chip erase.
        exp_mem(8'h06, 3'b000);
        send(16'h8300);
        drain("mem_wren");
        exp_mem(8'hC7, 3'b000);
        send(16'h8400);
        drain("mem_erase");

        // GET with the transmitter never answering: timeout.
        tx_mode = TX_LOW;
        exp_tx(48'h3333, 3'b010);
        send(16'h3300);
        k = 0;
        while (!TX_TRIG && k < 50) begin
            @(negedge CLK);
            k++;
        end
        check("tmo_trig_seen", 64'(k < 50), 1);
        repeat (20) @(negedge CLK);
        check("tmo_trig_held", TX_TRIG, 1);
        check("tmo_not_yet", TMO_ERR, 0);
        repeat (20) @(negedge CLK);
        check("tmo_trig_dropped", TX_TRIG, 0);
        check("tmo_err_set", TMO_ERR, 1);
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        check("err_clr_tmo", TMO_ERR, 0);
        check("err_clr_overflow", OVERFLOW, 0);
        tx_mode = TX_AUTO;
        drain("timeout");

        // Reset in the middle of a memory operation.
        exp_tx(48'h329A, 3'b010);
        send(16'h229A);
        send(16'h3200);
        drain("pre_reset");
        mem_hold = 1'b1;
        exp_mem(8'h05, 3'b001);
        send(16'h8000);
        k = 0;
        while (!MEM_BUSY && k < 50) begin
            @(negedge CLK);
            k++;
        end
        check("mem_busy_seen", 64'(k < 50), 1);
        repeat (3) @(negedge CLK);
        send(16'h3100);
        check("pre_reset_mem_cmd", MEM_CMD, 8'h05);
        RST_N = 1'b0;
        #1;
        check("async_rst_trigs", {TX_TRIG, MEM_TRIG}, 0);
        check("async_rst_data", {TX_DATA, TX_TYPE, MEM_CMD, MEM_TYPE_OUT}, 0);
        check("async_rst_flags", {OVERFLOW, TMO_ERR}, 0);
        repeat (2) @(negedge CLK);
        mem_hold = 1'b0;
        RST_N = 1'b1;
        @(negedge CLK);
        exp_tx(48'h3222, 3'b010);
        send(16'h3200);
        exp_tx(48'h3111, 3'b010);
        send(16'h3100);
        drain("post_reset");

        check("tx_queue_empty", 64'(tx_q.size()), 0);
        check("mem_queue_empty", 64'(mem_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
